// File: rtl/tick_timer_if.sv
// Handshake bundle for tick_timer: run control and tick strobe in,
// run status and remaining count out.
interface tick_timer_if #(
    parameter int CNT_W = 16
);
    logic             tick_in;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] load_val;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;
    logic             tick_err;

    modport master (
        output tick_in, start, abort, load_val,
        input  busy, done, remaining, tick_err
    );

    modport slave (
        input  tick_in, start, abort, load_val,
        output busy, done, remaining, tick_err
    );
endinterface

// File: rtl/tick_timer.sv
// Tick-driven countdown timer: loads a tick count, counts external ticks down
// to zero, pulses done, and flags a stalled tick source via a watchdog.
module tick_timer #(
    parameter int CNT_W    = 16,
    parameter int WDOG_CYC = 64
) (
    input  logic         clk_in,
    input  logic         rst,
    tick_timer_if.slave  bus
);
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] remaining_q;
    logic [WD_W-1:0]  wdog;

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;
    assign bus.tick_err  = err_q;

    // NOTE: all state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            remaining_q <= '0;
            wdog        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // abort outranks a coincident start
                    if (bus.start && !bus.abort) begin
                        remaining_q <= bus.load_val;
                        err_q       <= 1'b0;
                        wdog        <= '0;
                        if (bus.load_val == '0) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            busy_q <= 1'b1;
                            state  <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (bus.abort) begin
                        remaining_q <= '0;
                        busy_q      <= 1'b0;
                        wdog        <= '0;
                        state       <= ST_IDLE;
                    end else if (bus.tick_in) begin
                        wdog <= '0;
                        // <= 1 rather than == 1 so the count can never wrap
                        if (remaining_q <= CNT_W'(1)) begin
                            remaining_q <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            remaining_q <= remaining_q - CNT_W'(1);
                        end
                    end else if (wdog < WD_W'(WDOG_CYC)) begin
                        wdog <= wdog + WD_W'(1);
                        if (wdog == WD_W'(WDOG_CYC - 1))
                            err_q <= 1'b1;
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b0;
                    wdog   <= '0;
                    state  <= ST_IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: per-cycle expectations go through a
// scoreboard queue; a vector table plus hand-built multi-cycle sequences.
module tb_tick_timer;
    localparam int CNT_W    = 16;
    localparam int WDOG_CYC = 64;

    typedef struct {
        bit               tick;
        bit               start;
        bit               abort;
        logic [CNT_W-1:0] load_val;
        bit               e_busy;
        bit               e_done;
        logic [CNT_W-1:0] e_rem;
        bit               e_err;
    } vec_t;

    typedef struct {
        bit               busy;
        bit               done;
        logic [CNT_W-1:0] rem;
        bit               err;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    tick_timer_if #(.CNT_W(CNT_W)) bus ();

    tick_timer #(.CNT_W(CNT_W), .WDOG_CYC(WDOG_CYC)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input exp_t e);
        n_checks++;
        if (bus.busy !== e.busy || bus.done !== e.done ||
            bus.remaining !== e.rem || bus.tick_err !== e.err) begin
            n_errors++;
            $display("FAIL %s: got busy=%0b done=%0b rem=%0d err=%0b, want busy=%0b done=%0b rem=%0d err=%0b",
                     name, bus.busy, bus.done, bus.remaining, bus.tick_err,
                     e.busy, e.done, e.rem, e.err);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic apply(input string name, input bit tick, input bit start, input bit abort,
                         input int lv, input bit eb, input bit ed, input int er, input bit ee);
        exp_t e;
        bus.tick_in  = tick;
        bus.start    = start;
        bus.abort    = abort;
        bus.load_val = CNT_W'(lv);
        e.busy = eb; e.done = ed; e.rem = CNT_W'(er); e.err = ee;
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, exp_q.pop_front());
        end
    endtask

    task automatic add(input bit t, input bit s, input bit a, input int lv,
                       input bit eb, input bit ed, input int er, input bit ee);
        vec_t v;
        v.tick = t; v.start = s; v.abort = a; v.load_val = CNT_W'(lv);
        v.e_busy = eb; v.e_done = ed; v.e_rem = CNT_W'(er); v.e_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t z;
        z.busy = 1'b0; z.done = 1'b0; z.rem = '0; z.err = 1'b0;
        bus.tick_in = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.load_val = '0;

        // Table: zero load, aborts, ignored start, start+abort, start/abort in DONE
        add(0,1,0,0, 0,1,0,0);  add(0,0,0,0, 0,0,0,0);
        add(0,1,0,5, 1,0,5,0);  add(1,0,0,0, 1,0,4,0);  add(1,0,0,0, 1,0,3,0);
        add(1,0,0,0, 1,0,2,0);  add(0,0,1,0, 0,0,0,0);  add(0,0,0,0, 0,0,0,0);
        add(0,1,0,5, 1,0,5,0);  add(1,0,0,0, 1,0,4,0);  add(1,0,0,0, 1,0,3,0);
        add(1,0,0,0, 1,0,2,0);  add(1,0,0,0, 1,0,1,0);  add(1,0,1,0, 0,0,0,0);
        add(0,0,0,0, 0,0,0,0);
        add(0,1,0,6, 1,0,6,0);  add(0,1,0,9, 1,0,6,0);  add(1,1,0,2, 1,0,5,0);
        add(0,0,1,0, 0,0,0,0);  add(0,1,1,7, 0,0,0,0);  add(0,0,0,7, 0,0,0,0);
        add(0,1,0,1, 1,0,1,0);  add(1,0,0,0, 0,1,0,0);  add(0,0,1,0, 0,0,0,0);
        add(0,1,0,1, 1,0,1,0);  add(1,0,0,0, 0,1,0,0);  add(0,1,0,3, 0,0,0,0);
        add(0,0,0,0, 0,0,0,0);

        repeat (2) @(posedge clk_in);
        #1;
        check("reset_hold", z);
        rst = 1'b0;
        apply("post_reset_idle", 0,0,0,0, 0,0,0,0);

        // load 3, tick every 10 cycles
        apply("r33_start", 0,1,0,3, 1,0,3,0);
        for (int k = 1; k <= 3; k++) begin
            for (int c = 0; c < 9; c++)
                apply("r33_wait", 0,0,0,0, 1,0,4-k,0);
            if (k < 3) apply("r33_tick", 1,0,0,0, 1,0,3-k,0);
            else       apply("r33_final", 1,0,0,0, 0,1,0,0);
        end
        apply("r33_done_cleared", 0,0,0,0, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].tick, vecs[i].start, vecs[i].abort,
                  int'(vecs[i].load_val), vecs[i].e_busy, vecs[i].e_done,
                  int'(vecs[i].e_rem), vecs[i].e_err);

        // watchdog: 63 silent cycles keep err low, the 64th raises it
        apply("wd_start", 0,1,0,4, 1,0,4,0);
        for (int c = 1; c < WDOG_CYC; c++)
            apply("wd_quiet", 0,0,0,0, 1,0,4,0);
        apply("wd_trip", 0,0,0,0, 1,0,4,1);
        apply("wd_sat", 0,0,0,0, 1,0,4,1);
        apply("wd_tick3", 1,0,0,0, 1,0,3,1);
        apply("wd_tick2", 1,0,0,0, 1,0,2,1);
        apply("wd_tick1", 1,0,0,0, 1,0,1,1);
        apply("wd_final", 1,0,0,0, 0,1,0,1);
        apply("wd_sticky", 0,0,0,0, 0,0,0,1);
        apply("wd_clear", 0,1,0,1, 1,0,1,0);
        apply("wd_clr_done", 1,0,0,0, 0,1,0,0);
        apply("wd_clr_idle", 0,0,0,0, 0,0,0,0);

        // async reset between edges mid-run
        apply("rst_start", 0,1,0,3, 1,0,3,0);
        apply("rst_tick", 1,0,0,0, 1,0,2,0);
        bus.tick_in = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", z);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        apply("rst_idle", 0,0,0,0, 0,0,0,0);
        apply("rst_restart", 0,1,0,2, 1,0,2,0);
        apply("rst_tick1", 1,0,0,0, 1,0,1,0);
        apply("rst_final", 1,0,0,0, 0,1,0,0);
        apply("rst_after", 0,0,0,0, 0,0,0,0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the load value and of the remaining count.
REQ-002 The block SHALL have parameter WDOG_CYC, default 64: number of clk_in cycles allowed in RUN without a tick_in before tick_err is raised.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk_in, input, 1 bit: sole clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port tick_in, input, 1 bit: single-cycle strobe from the clock divider; each high cycle is one tick.
REQ-007 The block SHALL have port start, input, 1 bit: request to load and run the timer.
REQ-008 The block SHALL have port load_val, input, CNT_W bits: tick count, sampled only when start is accepted.
REQ-009 The block SHALL have port abort, input, 1 bit: cancels a run in progress.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.
REQ-012 The block SHALL have port remaining, output, CNT_W bits: ticks still to elapse.
REQ-013 The block SHALL have port tick_err, output, 1 bit: sticky flag for a missing tick during RUN.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, start=1 with abort=0 SHALL be accepted: remaining<=load_val, tick_err<=0, and the FSM SHALL move to RUN, or to DONE if load_val==0.
REQ-016 Start accepted at edge N SHALL give busy=1 after edge N (one-cycle latency); for load_val==0, busy SHALL stay 0 and done SHALL be 1 after edge N.
REQ-017 start SHALL be ignored in RUN and DONE; load_val SHALL be ignored unless start is accepted.
REQ-018 In RUN, tick_in=1 SHALL decrement remaining by exactly 1 per high cycle; with tick_in=0, remaining SHALL hold.
REQ-019 In RUN, tick_in=1 with remaining==1 SHALL, at that edge, set remaining<=0, busy<=0, done<=1 and state<=DONE.
REQ-020 DONE SHALL last exactly one cycle (done=1), then return to IDLE with done=0.
REQ-021 remaining SHALL never wrap below 0.
REQ-022 In RUN, abort=1 SHALL move the FSM to IDLE next edge with remaining<=0, busy<=0 and no done pulse.
REQ-023 abort SHALL take priority over a simultaneous tick_in, including the final tick: no done pulse.
REQ-024 In IDLE, abort=1 SHALL take priority over a simultaneous start: start not accepted.
REQ-025 In DONE, abort SHALL have no effect.
REQ-026 In RUN, a watchdog counter SHALL count clk_in cycles and SHALL clear on tick_in=1 and on entry to RUN.
REQ-027 When the watchdog counter reaches WDOG_CYC, tick_err SHALL be set to 1 and the counter SHALL saturate.
REQ-028 tick_err SHALL stay 1 until the next accepted start or reset; the run SHALL continue normally regardless of tick_err.
REQ-029 The watchdog counter width SHALL be $clog2(WDOG_CYC+1).
REQ-030 The watchdog SHALL be inactive outside RUN.

Reset
REQ-031 rst=1 SHALL asynchronously force state=IDLE, busy=0, done=0, remaining=0, tick_err=0 and watchdog=0, independent of clk_in.
REQ-032 Reset asserted mid-RUN SHALL abandon the run with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-033 Bench: load_val=3, start, tick every 10 cycles -> busy=1 one cycle after start; remaining 3,2,1,0; done=1 exactly one cycle, on the edge of the 3rd tick; busy=0 at that same edge.
REQ-034 Bench: load_val=0, start -> done=1 for one cycle one edge after start; busy never 1.
REQ-035 Bench: load_val=5, abort at remaining=2; repeat with abort coincident with the final tick at remaining=1 -> IDLE, remaining=0, no done in either case.
REQ-036 Bench: load_val=4, tick_in held 0 for 64 cycles, then ticks resume -> tick_err=1 after the 64th cycle; remaining unchanged; run completes with done; tick_err cleared by the next start.
REQ-037 Bench: start pulsed in RUN with a different load_val -> ignored, remaining unaffected; start and abort together in IDLE -> not accepted.
REQ-038 Bench: rst asserted asynchronously mid-RUN between clock edges -> all outputs 0 immediately; a following start with load_val=2 completes normally.
